bp_mc_mmio_cmd_arbiter: RTL
===========================

Name: bp_mc_mmio_cmd_arbiter

Overview:
- Shares the single BlackParrot-to-manycore MMIO bridge among num_req_p BedRock mem-message requesters, for example uncached core I/O and a DMA or config engine.
- Grants commands round-robin and enforces a per-requester outstanding-credit limit.
- Records each granted requester's ID in an order FIFO.
- Steers the bridge's in-order responses back to the requester that issued each command.
- Sits directly between the requesters' io_cmd/io_resp ports and the bridge's io_cmd_i/io_resp_o ports.

Parameters:
num_req_p, 2, number of requesters; must be 2..8.
msg_width_p, 128, width of one packed BedRock mem message (header plus data), passed through opaquely.
max_outstanding_p, 8, total commands in flight; this is the depth of the order FIFO.
req_credits_p, 4, maximum commands in flight per requester; must be ≤ max_outstanding_p.

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  synchronous, active-low reset.
req_cmd_i  in  num_req_p*msg_width_p  requester commands; slice i belongs to requester i.
req_cmd_v_i  in  num_req_p  per-requester command valid.
req_cmd_ready_o  out  num_req_p  per-requester command ready; a transfer occurs when v&ready.
req_resp_o  out  msg_width_p  response message, broadcast to all requesters.
req_resp_v_o  out  num_req_p  one-hot response valid.
req_resp_yumi_i  in  num_req_p  per-requester response accept.
io_cmd_o  out  msg_width_p  command to the bridge.
io_cmd_v_o  out  1  command valid to the bridge.
io_cmd_ready_i  in  1  bridge command ready; must not depend on io_cmd_v_o.
io_resp_i  in  msg_width_p  bridge response.
io_resp_v_i  in  1  bridge response valid.
io_resp_yumi_o  out  1  response consumed.
outstanding_o  out  clog2(max_outstanding_p+1)  total commands in flight.
error_o  out  1  sticky flag: response arrived with no command outstanding.

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous, active-low, on reset_n_i.
  - Reset clears all per-requester counters, sets the round-robin pointer to 0, empties the order FIFO and clears error_o.
  - While reset_n_i=0, every valid/ready/yumi output is forced to 0; outstanding_o=0 and error_o=0.
- Eligibility: requester i is eligible when req_cmd_v_i[i] is 1, cnt[i]<req_credits_p, and the order FIFO is not full.
- Grant selection is combinational:
  - The grant is the first eligible requester searching upward from ptr, wrapping modulo num_req_p.
  - io_cmd_v_o = any eligible requester; io_cmd_o = req_cmd_i slice of the granted requester.
  - req_cmd_ready_o[g] = io_cmd_ready_i for the granted requester g; all other bits are 0.
  - Latency is 0 cycles: the command passes straight through.
- On a command transfer (io_cmd_v_o & io_cmd_ready_i):
  - push g into the order FIFO;
  - cnt[g] increments;
  - ptr becomes (g+1) mod num_req_p at the next edge.
  - With no transfer, ptr holds, including when the grant is stalled by io_cmd_ready_i=0. The grant may change while stalled if a requester drops valid.
- Response steering:
  - Let h = the order FIFO head.
  - req_resp_v_o[h] = io_resp_v_i & FIFO non-empty; all other bits are 0.
  - req_resp_o = io_resp_i.
  - io_resp_yumi_o = req_resp_v_o[h] & req_resp_yumi_i[h].
  - On yumi, pop the FIFO and decrement cnt[h]. Yumi bits for non-selected requesters are ignored.
- Simultaneous events:
  - Push and pop in the same cycle are both legal, including when the FIFO is full: the full check uses the registered state, so no push occurs when full, even if a pop happens that cycle.
  - If the same requester gets both increment and decrement, its cnt is unchanged.
  - outstanding_o equals the FIFO occupancy and changes by −1, 0 or +1 per cycle.
- Empty boundary: io_resp_v_i=1 while the FIFO is empty sets error_o at the next edge. The response is never acknowledged (io_resp_yumi_o stays 0), and error_o holds until reset.
- Counter arithmetic: each cnt is clog2(req_credits_p+1) bits and never wraps. A requester at req_credits_p is simply ineligible, and the others continue to be served.
- Reset mid-operation: all in-flight bookkeeping is discarded. The bridge must be reset in the same cycle.

Test Plan:
- Single requester 0 issues 4 commands back-to-back with io_cmd_ready_i=1 → 4 transfers on consecutive cycles, outstanding_o=4, 5th command ready=0. Returning 1 response → the 5th is accepted the next cycle.
- Both requesters continuously valid, num_req_p=2, ptr=0 after reset → grant order 0,1,0,1. Responses return with req_resp_v_o=01,10,01,10 in that order.
- io_cmd_ready_i=0 for 3 cycles with requester 1 valid → no push, ptr unchanged, req_cmd_ready_o=00. Ready rises → exactly one transfer.
- max_outstanding_p=8 with requesters 0 and 1 each holding 4 → FIFO full, no ready. A pop and new valid in the same cycle → no push that cycle, push the next cycle.
- io_resp_v_i=1 with an empty FIFO → error_o=1 next cycle, io_resp_yumi_o=0. reset_n_i=0 for 1 cycle → error_o=0, outstanding_o=0.
- Requester 1 response valid but req_resp_yumi_i=10 withheld for 5 cycles while requester 0 asserts yumi → no pop and counts unchanged until bit 1 is asserted.

Source files
------------

// File: rtl/bp_mc_mmio_cmd_arbiter_if.sv
// Requester-side and bridge-side command/response signals of the MMIO command arbiter.
// The master modport is the arbiter's view; slave is the view of the requesters plus bridge.
interface bp_mc_mmio_cmd_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 128
);
    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_ready_o;
    logic [msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_yumi_i;

    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_ready_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_yumi_o;

    modport master (
        input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        input  io_cmd_ready_i, io_resp_i, io_resp_v_i,
        output req_cmd_ready_o, req_resp_o, req_resp_v_o,
        output io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );

    modport slave (
        output req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        output io_cmd_ready_i, io_resp_i, io_resp_v_i,
        input  req_cmd_ready_o, req_resp_o, req_resp_v_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );
endinterface

// File: rtl/bp_mc_mmio_cmd_arbiter.sv
// Round-robin arbiter sharing one in-order MMIO bridge among several requesters.
// Grants are logged in an order FIFO so in-order responses return to their issuer.
module bp_mc_mmio_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 8,
    parameter int req_credits_p     = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    bp_mc_mmio_cmd_arbiter_if.master               bus,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   error_o
);

    localparam int cnt_w   = $clog2(req_credits_p + 1);
    localparam int id_w    = $clog2(num_req_p);
    localparam int fifo_aw = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int occ_w   = $clog2(max_outstanding_p + 1);

    if (num_req_p < 2 || num_req_p > 8) begin : g_bad_num_req
        $error("bp_mc_mmio_cmd_arbiter: num_req_p must be 2..8");
    end
    if (req_credits_p > max_outstanding_p) begin : g_bad_credits
        $error("bp_mc_mmio_cmd_arbiter: req_credits_p exceeds max_outstanding_p");
    end

    logic [cnt_w-1:0]   cnt [num_req_p];
    logic [id_w-1:0]    ptr;
    logic [id_w-1:0]    order_mem [max_outstanding_p];
    logic [fifo_aw-1:0] wr_addr;
    logic [fifo_aw-1:0] rd_addr;
    logic [occ_w-1:0]   occupancy;
    logic               error_r;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [num_req_p-1:0] eligible;
    logic [id_w-1:0]      grant;
    logic                 grant_found;
    logic [id_w-1:0]      head;
    logic                 resp_sel;
    logic                 cmd_push;
    logic                 resp_pop;
    logic [num_req_p-1:0] cnt_inc;
    logic [num_req_p-1:0] cnt_dec;

    function automatic logic [fifo_aw-1:0] next_addr(input logic [fifo_aw-1:0] addr);
        return (addr == fifo_aw'(max_outstanding_p - 1)) ? '0 : addr + fifo_aw'(1);
    endfunction

    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
    assign fifo_full  = (occupancy == occ_w'(max_outstanding_p));
    assign fifo_empty = (occupancy == '0);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < num_req_p; i++) begin
            eligible[i] = bus.req_cmd_v_i[i] && (cnt[i] < cnt_w'(req_credits_p)) && !fifo_full;
        end
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = (int'(ptr) + k) % num_req_p;
            if (!grant_found && eligible[idx]) begin
                grant       = id_w'(idx);
                grant_found = 1'b1;
            end
        end
    end

    assign bus.io_cmd_v_o = reset_n_i && grant_found;
    assign bus.io_cmd_o   = bus.req_cmd_i[int'(grant)*msg_width_p +: msg_width_p];
    assign cmd_push       = bus.io_cmd_v_o && bus.io_cmd_ready_i;

    always_comb begin
        bus.req_cmd_ready_o = '0;
        if (reset_n_i && grant_found) begin
            bus.req_cmd_ready_o[grant] = bus.io_cmd_ready_i;
        end
    end

    assign head     = order_mem[rd_addr];
    assign resp_sel = reset_n_i && bus.io_resp_v_i && !fifo_empty;

    always_comb begin
        bus.req_resp_v_o = '0;
        if (resp_sel) begin
            bus.req_resp_v_o[head] = 1'b1;
        end
    end

    assign bus.req_resp_o     = bus.io_resp_i;
    assign bus.io_resp_yumi_o = resp_sel && bus.req_resp_yumi_i[head];
    assign resp_pop           = bus.io_resp_yumi_o;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cnt_inc[i] = cmd_push && (grant == id_w'(i));
            cnt_dec[i] = resp_pop && (head == id_w'(i));
        end
    end

    // Order storage needs no reset: only entries between rd_addr and wr_addr are ever read.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && cmd_push) begin
            order_mem[wr_addr] <= grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr       <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            occupancy <= '0;
            error_r   <= 1'b0;
            for (int i = 0; i < num_req_p; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (cmd_push) begin
                wr_addr <= next_addr(wr_addr);
                ptr     <= (grant == id_w'(num_req_p - 1)) ? '0 : grant + id_w'(1);
            end
            if (resp_pop) begin
                rd_addr <= next_addr(rd_addr);
            end
            if (cmd_push && !resp_pop) begin
                occupancy <= occupancy + occ_w'(1);
            end else if (resp_pop && !cmd_push) begin
                occupancy <= occupancy - occ_w'(1);
            end
            if (bus.io_resp_v_i && fifo_empty) begin
                error_r <= 1'b1;
            end
            for (int i = 0; i < num_req_p; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt[i] <= cnt[i] + cnt_w'(1);
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    cnt[i] <= cnt[i] - cnt_w'(1);
                end
            end
        end
    end

    assign outstanding_o = reset_n_i ? occupancy : '0;
    assign error_o       = reset_n_i && error_r;

endmodule
